// File: rtl/vec_mul_unit.sv
// Iterative unsigned WIDTH x WIDTH multiplier using DIGIT-bit radix shift-add.
// One multiplier digit is retired per clock, so an operation takes WIDTH/DIGIT cycles.
module vec_mul_unit #(
    parameter int WIDTH = 512,
    parameter int DIGIT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                 state_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       p_hi_q;
    logic [WIDTH-1:0]       p_lo_q;
    logic [WIDTH-1:0]       res_lo_q;
    logic [WIDTH-1:0]       res_hi_q;
    logic [CW-1:0]          count_q;
    logic                   done_q;

    logic [WIDTH+DIGIT-1:0] sum_d;
    logic [WIDTH-1:0]       p_hi_d;
    logic [WIDTH-1:0]       p_lo_d;

    // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
    always_comb begin
        sum_d  = {{DIGIT{1'b0}}, p_hi_q}
               + ({{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, p_lo_q[DIGIT-1:0]});
        p_hi_d = sum_d[WIDTH+DIGIT-1:DIGIT];
        p_lo_d = {sum_d[DIGIT-1:0], p_lo_q[WIDTH-1:DIGIT]};
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !clear) begin
                        a_q     <= op_a;
                        p_lo_q  <= op_b;
                        p_hi_q  <= '0;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q <= IDLE;
                    end else begin
                        p_hi_q  <= p_hi_d;
                        p_lo_q  <= p_lo_d;
                        count_q <= count_q + 1'b1;
                        // Results only move on the final digit so they never expose partial sums.
                        if (count_q == LAST) begin
                            state_q  <= IDLE;
                            res_hi_q <= p_hi_d;
                            res_lo_q <= p_lo_d;
                            done_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_vec_mul_unit.sv
// Directed and random self-checking bench for vec_mul_unit at the default 512/32 configuration.
// Expected products are hand constants or a full-width multiply done by the bench.
module tb_vec_mul_unit;

    localparam int W = 512;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         clear;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;

    int total = 0;
    int bad   = 0;

    vec_mul_unit #(.WIDTH(W), .DIGIT(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_busy", W'(busy), W'(1));
        check("accept_done_low", W'(done), W'(0));
    endtask

    task automatic wait_done(input int already, input int want, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo);
        int n;
        n = already;
        while (done !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check("done_latency", W'(n), W'(want));
        check("result_lo", result_lo, exp_lo);
        check("result_hi", result_hi, exp_hi);
        check("done_busy_low", W'(busy), W'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        accept(a, b);
        wait_done(0, 16, exp_hi, exp_lo);
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check(tag, W'(seen), W'(0));
    endtask

    initial begin
        logic [W-1:0]   ones;
        logic [W-1:0]   top_bit;
        logic [W-1:0]   hi_ones;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] prod;

        ones    = '1;
        top_bit = {1'b1, {(W-1){1'b0}}};
        hi_ones = {{(W-1){1'b1}}, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        op_a  = '0;
        op_b  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_lo", result_lo, '0);
        check("rst_hi", result_hi, '0);

        // 3 x 5 with a look at the outputs mid-run.
        accept(W'(3), W'(5));
        repeat (5) tick();
        check("mid_run_busy", W'(busy), W'(1));
        check("mid_run_lo_hold", result_lo, '0);
        wait_done(5, 16, '0, W'(15));
        tick();
        check("done_one_cycle", W'(done), W'(0));
        check("result_hold", result_lo, W'(15));

        run_op(ones, ones, hi_ones, W'(1));
        tick();
        run_op(top_bit, W'(2), W'(1), '0);
        tick();
        run_op('0, rnd(), '0, '0);

        // Start pulse during RUN with changing operands must be ignored.
        tick();
        accept(W'(3), W'(5));
        repeat (3) tick();
        op_a  = W'(7);
        op_b  = W'(7);
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = rnd();
        op_b  = rnd();
        wait_done(4, 16, '0, W'(15));
        run_op(W'(7), W'(7), '0, W'(49));
        watch_no_done(20, "no_queued_done");

        // Clear at RUN cycle 5.
        run_op(W'(3), W'(5), '0, W'(15));
        tick();
        accept(W'(2), W'(2));
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", W'(busy), W'(0));
        check("clear_done", W'(done), W'(0));
        check("clear_lo_hold", result_lo, W'(15));
        watch_no_done(20, "clear_no_done");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("idle_clear_busy", W'(busy), W'(0));
        check("idle_clear_lo", result_lo, W'(15));

        op_a  = W'(2);
        op_b  = W'(2);
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("clear_beats_start", W'(busy), W'(0));
        watch_no_done(20, "dropped_start_no_done");

        // Asynchronous reset at RUN cycle 8, asserted between clock edges.
        accept(W'(2), W'(2));
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("async_rst_busy", W'(busy), W'(0));
        check("async_rst_done", W'(done), W'(0));
        check("async_rst_lo", result_lo, '0);
        check("async_rst_hi", result_hi, '0);
        tick();
        reset = 1'b0;
        watch_no_done(20, "rst_no_done");
        check("rst_lo_after", result_lo, '0);

        // Random back-to-back operations against a full-width reference product.
        for (int i = 0; i < 200; i++) begin
            ra   = rnd();
            rb   = rnd();
            if (i % 16 == 3) rb[W-1:W/2] = '0;
            prod = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_op(ra, rb, prod[2*W-1:W], prod[W-1:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
